multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
 - clk  in  1  system clock, rising edge
 - reset  in  1  asynchronous, active-low reset
 - opcode_i  in  6  instruction[31:26] from the instruction register
 - mem_ready_i  in  1  memory handshake; 1 = access completes this cycle
 - pc_write_o  out  1  PC load strobe
 - pc_source_o  out  2  00 = ALU result, 10 = jump target
 - ir_write_o  out  1  instruction register load strobe
 - mem_read_o  out  1  memory read request
 - mem_write_o  out  1  memory write request
 - i_or_d_o  out  1  0 = PC address, 1 = ALU-out address
 - reg_write_o  out  1  register file write strobe
 - reg_dst_o  out  1  1 = rd, 0 = rt
 - mem_to_reg_o  out  1  1 = memory data, 0 = ALU-out
 - alu_src_a_o  out  1  0 = PC, 1 = rs
 - alu_src_b_o  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = zero-extended imm
 - alu_op_o  out  3  ALU-control operation class
 - state_o  out  3  current state (debug)
 - illegal_o  out  1  sticky illegal-opcode flag
 - instr_count_o  out  32  retired-instruction counter
REQ-002 The block SHALL use one clock domain, clk; reset SHALL be asynchronous and active-low.

Function
REQ-003 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-004 Legal opcodes SHALL be: R-type 000000, ADDI 001000, ORI 001101, LUI 001111, LW 100011, SW 101011, J 000010; all others are illegal.
REQ-005 alu_op_o encoding SHALL be: 111 R-type (funct decides), 100 add, 101 or, 110 lui; its value is 100 in every state not listed below.
REQ-006 FETCH: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=100. If mem_ready_i=1: ir_write_o=1, pc_write_o=1, pc_source_o=00, and next state = DECODE. Otherwise all write strobes = 0 and the state holds.
REQ-007 DECODE: opcode_i SHALL be captured into an internal opcode register.
 - J: pc_write_o=1, pc_source_o=10, next state FETCH.
 - Other legal opcodes: next state EXEC.
 - Illegal opcode: next state TRAP.
REQ-008 EXEC SHALL use the captured opcode only, with alu_src_a_o=1.
 - R-type: alu_src_b_o=00, alu_op_o=111.
 - ADDI, LW, SW: alu_src_b_o=10, alu_op_o=100.
 - ORI: alu_src_b_o=11, alu_op_o=101.
 - LUI: alu_src_b_o=10, alu_op_o=110.
 - Next state: MEM for LW/SW, otherwise WB.
REQ-009 MEM: i_or_d_o=1; mem_read_o=1 for LW, mem_write_o=1 for SW. The state SHALL hold while mem_ready_i=0. On mem_ready_i=1: LW goes to WB, SW goes to FETCH.
REQ-010 WB: reg_write_o=1; reg_dst_o=1 only for R-type; mem_to_reg_o=1 only for LW; next state FETCH.
REQ-011 TRAP: all strobes = 0 and illegal_o=1; the state SHALL hold until reset.
REQ-012 All outputs except state_o, illegal_o and instr_count_o SHALL be combinational functions of the state, the captured opcode and mem_ready_i. Unlisted strobes SHALL be 0.
REQ-013 instr_count_o SHALL increment by 1 on each transition into FETCH from WB, MEM (SW) or DECODE (J), and SHALL wrap from FFFFFFFF to 0.
REQ-014 A change of mem_ready_i in any state other than FETCH or MEM SHALL have no effect.
REQ-015 Instruction latency with mem_ready_i held at 1 SHALL be:
 - J: 2 cycles
 - R-type, ADDI, ORI, LUI, SW: 4 cycles
 - LW: 5 cycles
 - plus 1 cycle for each wait cycle in FETCH or MEM.

Reset
REQ-016 While reset=0, the state SHALL be FETCH, the captured opcode 000000, illegal_o=0, instr_count_o=0, and every strobe output 0, even if the reset arrives mid-instruction.
REQ-017 On the first clock after reset is released, the FETCH outputs of REQ-006 SHALL apply.
REQ-018 Reset SHALL be the only exit from TRAP.

Verification
REQ-019 ADDI, mem_ready_i=1 -> states 0,1,2,4,0; alu_op_o=100 and alu_src_b_o=10 in EXEC; reg_write_o=1 for one cycle; instr_count_o=1.
REQ-020 LW, with mem_ready_i=0 for 2 cycles in MEM -> 7 cycles total; mem_read_o and i_or_d_o high for 3 MEM cycles; mem_to_reg_o=1 in WB.
REQ-021 SW -> MEM then FETCH; mem_write_o pulses once; reg_write_o never asserts; instr_count_o increments once.
REQ-022 J -> 2 cycles; pc_write_o=1 and pc_source_o=10 in DECODE; EXEC is never entered.
REQ-023 opcode_i=111111 -> TRAP; illegal_o=1; no strobes asserted over 20 further cycles; instr_count_o unchanged.
REQ-024 reset asserted during the MEM wait of an LW -> mem_read_o drops immediately; after release, state_o=0 and instr_count_o=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// with an opcode capture register, a sticky illegal flag and a retired-instruction counter.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic [1:0]  pc_source_o,
    output logic        ir_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        i_or_d_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instr_count_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_FUNCT = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_J: is_legal = 1'b1;
            default:                                               is_legal = 1'b0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic        retire;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            opcode_q      <= 6'b000000;
            illegal_q     <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // The capture register is not loaded yet, so J is resolved from the live opcode.
                opcode_d = opcode_i;
                if (opcode_i == OP_J) begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_legal(opcode_i)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_WB;
                case (opcode_q)
                    OP_RTYPE: begin
                        alu_src_b = 2'b00;
                        alu_op    = ALU_FUNCT;
                    end
                    OP_ADDI: alu_src_b = 2'b10;
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_ORI: begin
                        alu_src_b = 2'b11;
                        alu_op    = ALU_OR;
                    end
                    OP_LUI: begin
                        alu_src_b = 2'b10;
                        alu_op    = ALU_LUI;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode_q == OP_LW);
                mem_write = (opcode_q == OP_SW);
                if (mem_ready_i) begin
                    if (opcode_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = (opcode_q == OP_SW);
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode_q == OP_RTYPE);
                mem_to_reg = (opcode_q == OP_LW);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
    end

    // Strobes are forced low combinationally so an asserted reset silences them at once.
    assign pc_write_o    = pc_write  & reset;
    assign ir_write_o    = ir_write  & reset;
    assign mem_read_o    = mem_read  & reset;
    assign mem_write_o   = mem_write & reset;
    assign reg_write_o   = reg_write & reset;
    assign pc_source_o   = pc_source;
    assign i_or_d_o      = i_or_d;
    assign reg_dst_o     = reg_dst;
    assign mem_to_reg_o  = mem_to_reg;
    assign alu_src_a_o   = alu_src_a;
    assign alu_src_b_o   = alu_src_b;
    assign alu_op_o      = alu_op;
    assign state_o       = state_q;
    assign illegal_o     = illegal_q;
    assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control: every instruction class,
// memory wait states, trap behaviour and asynchronous reset mid-instruction.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode_i;
    logic        mem_ready_i;
    logic        pc_write_o;
    logic [1:0]  pc_source_o;
    logic        ir_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        i_or_d_o;
    logic        reg_write_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic [2:0]  state_o;
    logic        illegal_o;
    logic [31:0] instr_count_o;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode_i      (opcode_i),
        .mem_ready_i   (mem_ready_i),
        .pc_write_o    (pc_write_o),
        .pc_source_o   (pc_source_o),
        .ir_write_o    (ir_write_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .i_or_d_o      (i_or_d_o),
        .reg_write_o   (reg_write_o),
        .reg_dst_o     (reg_dst_o),
        .mem_to_reg_o  (mem_to_reg_o),
        .alu_src_a_o   (alu_src_a_o),
        .alu_src_b_o   (alu_src_b_o),
        .alu_op_o      (alu_op_o),
        .state_o       (state_o),
        .illegal_o     (illegal_o),
        .instr_count_o (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] LUI = 6'b001111;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    // Output word: pcw pcs[2] irw mr mw iord rw rd m2r sa sb[2] op[3]
    localparam logic [15:0] O_RST    = 16'b0_00_0_0_0_0_0_0_0_0_01_100;
    localparam logic [15:0] O_F_RDY  = 16'b1_00_1_1_0_0_0_0_0_0_01_100;
    localparam logic [15:0] O_F_WAIT = 16'b0_00_0_1_0_0_0_0_0_0_01_100;
    localparam logic [15:0] O_DEC    = 16'b0_00_0_0_0_0_0_0_0_0_00_100;
    localparam logic [15:0] O_DEC_J  = 16'b1_10_0_0_0_0_0_0_0_0_00_100;
    localparam logic [15:0] O_EX_R   = 16'b0_00_0_0_0_0_0_0_0_1_00_111;
    localparam logic [15:0] O_EX_ADD = 16'b0_00_0_0_0_0_0_0_0_1_10_100;
    localparam logic [15:0] O_EX_ORI = 16'b0_00_0_0_0_0_0_0_0_1_11_101;
    localparam logic [15:0] O_EX_LUI = 16'b0_00_0_0_0_0_0_0_0_1_10_110;
    localparam logic [15:0] O_MEM_LW = 16'b0_00_0_1_0_1_0_0_0_0_00_100;
    localparam logic [15:0] O_MEM_SW = 16'b0_00_0_0_1_1_0_0_0_0_00_100;
    localparam logic [15:0] O_WB_R   = 16'b0_00_0_0_0_0_1_1_0_0_00_100;
    localparam logic [15:0] O_WB_LW  = 16'b0_00_0_0_0_0_1_0_1_0_00_100;
    localparam logic [15:0] O_WB_I   = 16'b0_00_0_0_0_0_1_0_0_0_00_100;
    localparam logic [15:0] O_TRAP   = 16'b0_00_0_0_0_0_0_0_0_0_00_100;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [2:0]  st;
        logic [15:0] out;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic rdy,
                                input logic [2:0] st, input logic [15:0] out,
                                input logic ill, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st;
        v.out = out; v.ill = ill; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {pc_write_o, pc_source_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o,
                reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o};
    endfunction

    task automatic check_now(input string name, input logic [2:0] st, input logic [15:0] out,
                             input logic ill, input logic [31:0] cnt);
        checks++;
        if (state_o !== st) begin
            errors++;
            $display("FAIL %s state: got %0d want %0d", name, state_o, st);
        end
        checks++;
        if (outs() !== out) begin
            errors++;
            $display("FAIL %s outputs: got %b want %b", name, outs(), out);
        end
        checks++;
        if (illegal_o !== ill) begin
            errors++;
            $display("FAIL %s illegal: got %b want %b", name, illegal_o, ill);
        end
        checks++;
        if (instr_count_o !== cnt) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, instr_count_o, cnt);
        end
    endtask

    task automatic step(input string name, input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [2:0] st, input logic [15:0] out,
                        input logic ill, input logic [31:0] cnt);
        @(negedge clk);
        reset       = rst;
        opcode_i    = op;
        mem_ready_i = rdy;
        #1;
        check_now(name, st, out, ill, cnt);
    endtask

    initial begin
        // Reset, then ADDI; opcode_i changes in EXEC to show the captured opcode is used
        vecs[0]  = mk(0, ADI, 1, 0, O_RST,    0, 0);
        vecs[1]  = mk(0, ADI, 1, 0, O_RST,    0, 0);
        vecs[2]  = mk(1, ADI, 1, 0, O_F_RDY,  0, 0);
        vecs[3]  = mk(1, ADI, 1, 1, O_DEC,    0, 0);
        vecs[4]  = mk(1, R,   1, 2, O_EX_ADD, 0, 0);
        vecs[5]  = mk(1, R,   0, 4, O_WB_I,   0, 0);
        // LW with a fetch wait and two memory waits
        vecs[6]  = mk(1, LW,  0, 0, O_F_WAIT, 0, 1);
        vecs[7]  = mk(1, LW,  1, 0, O_F_RDY,  0, 1);
        vecs[8]  = mk(1, LW,  1, 1, O_DEC,    0, 1);
        vecs[9]  = mk(1, LW,  0, 2, O_EX_ADD, 0, 1);
        vecs[10] = mk(1, LW,  0, 3, O_MEM_LW, 0, 1);
        vecs[11] = mk(1, LW,  0, 3, O_MEM_LW, 0, 1);
        vecs[12] = mk(1, LW,  1, 3, O_MEM_LW, 0, 1);
        vecs[13] = mk(1, LW,  1, 4, O_WB_LW,  0, 1);
        // SW
        vecs[14] = mk(1, SW,  1, 0, O_F_RDY,  0, 2);
        vecs[15] = mk(1, SW,  1, 1, O_DEC,    0, 2);
        vecs[16] = mk(1, SW,  1, 2, O_EX_ADD, 0, 2);
        vecs[17] = mk(1, SW,  1, 3, O_MEM_SW, 0, 2);
        // J
        vecs[18] = mk(1, J,   1, 0, O_F_RDY,  0, 3);
        vecs[19] = mk(1, J,   1, 1, O_DEC_J,  0, 3);
        // R-type
        vecs[20] = mk(1, R,   1, 0, O_F_RDY,  0, 4);
        vecs[21] = mk(1, R,   1, 1, O_DEC,    0, 4);
        vecs[22] = mk(1, R,   1, 2, O_EX_R,   0, 4);
        vecs[23] = mk(1, R,   1, 4, O_WB_R,   0, 4);
        // ORI
        vecs[24] = mk(1, ORI, 1, 0, O_F_RDY,  0, 5);
        vecs[25] = mk(1, ORI, 1, 1, O_DEC,    0, 5);
        vecs[26] = mk(1, ORI, 1, 2, O_EX_ORI, 0, 5);
        vecs[27] = mk(1, ORI, 1, 4, O_WB_I,   0, 5);
        // LUI
        vecs[28] = mk(1, LUI, 1, 0, O_F_RDY,  0, 6);
        vecs[29] = mk(1, LUI, 1, 1, O_DEC,    0, 6);
        vecs[30] = mk(1, LUI, 1, 2, O_EX_LUI, 0, 6);
        vecs[31] = mk(1, LUI, 1, 4, O_WB_I,   0, 6);
        // Illegal opcode
        vecs[32] = mk(1, BAD, 1, 0, O_F_RDY,  0, 7);
        vecs[33] = mk(1, BAD, 1, 1, O_DEC,    0, 7);
        vecs[34] = mk(1, BAD, 1, 5, O_TRAP,   1, 7);

        reset       = 1'b1;
        opcode_i    = 6'b0;
        mem_ready_i = 1'b0;
        #1 reset    = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].rdy,
                 vecs[i].st, vecs[i].out, vecs[i].ill, vecs[i].cnt);
        end

        // TRAP holds with no strobes regardless of inputs
        for (int i = 0; i < 20; i++) begin
            logic [5:0] op;
            logic       rdy;
            op  = 6'(i * 3);
            rdy = (i % 2) == 0;
            step($sformatf("trap%0d", i), 1, op, rdy, 5, O_TRAP, 1, 7);
        end

        step("trap_reset", 0, R, 1, 0, O_RST, 0, 0);

        // J then LW into a memory wait, interrupted by reset
        step("j_fetch",   1, J,  1, 0, O_F_RDY,  0, 0);
        step("j_decode",  1, J,  1, 1, O_DEC_J,  0, 0);
        step("lw_fetch",  1, LW, 1, 0, O_F_RDY,  0, 1);
        step("lw_decode", 1, LW, 1, 1, O_DEC,    0, 1);
        step("lw_exec",   1, LW, 0, 2, O_EX_ADD, 0, 1);
        step("lw_wait",   1, LW, 0, 3, O_MEM_LW, 0, 1);
        #1 reset = 1'b0;
        #1 check_now("async_reset", 0, O_RST, 0, 0);
        step("held_reset", 0, LW, 0, 0, O_RST,    0, 0);
        step("release",    1, LW, 0, 0, O_F_WAIT, 0, 0);
        step("post_fetch", 1, LW, 1, 0, O_F_RDY,  0, 0);
        step("post_dec",   1, LW, 1, 1, O_DEC,    0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
